module_instruction_fetch: RTL and testbench

MODULE_INSTRUCTION_FETCH -- requirements
Module: module_instruction_fetch

---
 rtl/module_instruction_fetch_pkg.sv | 14 +
 rtl/module_instruction_fetch_if.sv | 27 ++
 rtl/module_instruction_fetch_queue.sv | 58 +++++
 rtl/module_instruction_fetch.sv | 79 +++++++
 tb/tb_module_instruction_fetch.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/module_instruction_fetch_pkg.sv
// Shared constants and the queue entry layout for the instruction fetch block.
package module_instruction_fetch_pkg;

    localparam int          DEFAULT_DEPTH = 4;
    localparam logic [31:0] NOP_INSTR     = 32'h00000013;

    // 65-bit queue entry: instruction word, fetch pc, misaligned flag.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        misaligned;
    } fetch_entry_t;

endpackage

// File: rtl/module_instruction_fetch_if.sv
// Fetch request, memory and decode-side signals of the instruction fetch block.
interface module_instruction_fetch_if;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        mem_en;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_misaligned;
    logic        instr_ready;

    modport master (
        output req_valid, req_addr, flush, mem_rdata, instr_ready,
        input  req_ready, mem_en, mem_addr, instr_valid, instr, instr_pc, instr_misaligned
    );

    modport slave (
        input  req_valid, req_addr, flush, mem_rdata, instr_ready,
        output req_ready, mem_en, mem_addr, instr_valid, instr, instr_pc, instr_misaligned
    );

endinterface

// File: rtl/module_instruction_fetch_queue.sv
// In-order instruction queue; pointers wrap naturally since DEPTH is a power of two.
module fetch_queue
    import module_instruction_fetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output logic                   head_valid,
    output fetch_entry_t           head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   slots [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_pop;

    assign do_pop     = pop && (count != '0);
    assign head_valid = (count != '0);
    assign head_data  = head_valid ? slots[rd_ptr] : '0;

    // Entry storage; stale slots are never visible because head is gated by count.
    always_ff @(posedge clock) begin
        if (push) begin
            slots[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; clear (flush) drops everything including a same-cycle push.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/module_instruction_fetch.sv
// Instruction fetch: credit-limited requests, one-cycle memory read, queued results.
module module_instruction_fetch
    import module_instruction_fetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input logic                       clock,
    input logic                       reset,
    module_instruction_fetch_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          inflight;
    logic [31:0]   inflight_pc;
    logic          inflight_mis;
    logic [29:0]   mem_addr_q;
    logic [CW-1:0] count;
    logic [CW-1:0] used;
    logic          accept;
    logic          push;
    logic          pop;
    logic          head_valid;
    fetch_entry_t  push_data;
    fetch_entry_t  head_data;

    // Credits count queued entries plus the one outstanding read; instr_ready is not involved.
    assign used          = count + CW'(inflight);
    assign bus.req_ready = reset && !bus.flush && (used < CW'(DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.mem_en    = accept;
    assign bus.mem_addr  = accept ? bus.req_addr[31:2] : mem_addr_q;

    assign push = inflight && !bus.flush;
    assign pop  = head_valid && bus.instr_ready && !bus.flush;

    // Build the entry for the returning read; misaligned fetches become a NOP.
    always_comb begin
        push_data            = '0;
        push_data.instr      = inflight_mis ? NOP_INSTR : bus.mem_rdata;
        push_data.pc         = inflight_pc;
        push_data.misaligned = inflight_mis;
    end

    // Outstanding-read tag and held memory address; reset drops any read in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            inflight     <= 1'b0;
            inflight_pc  <= '0;
            inflight_mis <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            inflight <= accept;
            if (accept) begin
                inflight_pc  <= bus.req_addr;
                inflight_mis <= |bus.req_addr[1:0];
                mem_addr_q   <= bus.req_addr[31:2];
            end
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clock      (clock),
        .reset      (reset),
        .clear      (bus.flush),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_data),
        .count      (count)
    );

    assign bus.instr_valid      = head_valid;
    assign bus.instr            = head_data.instr;
    assign bus.instr_pc         = head_data.pc;
    assign bus.instr_misaligned = head_data.misaligned;

endmodule

// File: tb/tb_module_instruction_fetch.sv
// Directed bench for module_instruction_fetch: vector table plus multi-cycle sequences.
module tb_module_instruction_fetch;

    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    module_instruction_fetch_if bus();

    module_instruction_fetch #(.DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model word for a given word address.
    function automatic logic [31:0] mem_word(input logic [29:0] w);
        return 32'h0000000A + {2'b00, w};
    endfunction

    // Instruction memory: data one cycle after the strobe, garbage otherwise.
    always @(posedge clock) begin
        bus.mem_rdata <= bus.mem_en ? mem_word(bus.mem_addr) : 32'hDEADBEEF;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rv;
        logic [31:0] addr;
        logic        fl;
        logic        ir;
        logic        e_rr;
        logic        e_me;
        logic [29:0] e_ma;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] addr, input logic fl, input logic ir);
        bus.req_valid   = rv;
        bus.req_addr    = addr;
        bus.flush       = fl;
        bus.instr_ready = ir;
    endtask

    initial begin
        int accepts;
        int n_sent;
        int n_recv;

        // rv addr fl ir | req_ready mem_en mem_addr instr_valid instr pc misaligned
        vecs[0]  = '{1'b1, 32'h00, 1'b0, 1'b1, 1'b1, 1'b1, 30'd0, 1'b0, 32'h0,  32'h0, 1'b0};
        vecs[1]  = '{1'b1, 32'h04, 1'b0, 1'b1, 1'b1, 1'b1, 30'd1, 1'b0, 32'h0,  32'h0, 1'b0};
        vecs[2]  = '{1'b1, 32'h08, 1'b0, 1'b1, 1'b1, 1'b1, 30'd2, 1'b1, 32'hA,  32'h0, 1'b0};
        vecs[3]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 30'd2, 1'b1, 32'hB,  32'h4, 1'b0};
        vecs[4]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 30'd2, 1'b1, 32'hC,  32'h8, 1'b0};
        vecs[5]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 30'd2, 1'b0, 32'h0,  32'h0, 1'b0};
        vecs[6]  = '{1'b1, 32'h06, 1'b0, 1'b0, 1'b1, 1'b1, 30'd1, 1'b0, 32'h0,  32'h0, 1'b0};
        vecs[7]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 30'd1, 1'b0, 32'h0,  32'h0, 1'b0};
        vecs[8]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 30'd1, 1'b1, 32'h13, 32'h6, 1'b1};
        vecs[9]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 30'd1, 1'b0, 32'h0,  32'h0, 1'b0};
        vecs[10] = '{1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 1'b1, 30'd4, 1'b0, 32'h0,  32'h0, 1'b0};
        vecs[11] = '{1'b1, 32'h14, 1'b1, 1'b1, 1'b0, 1'b0, 30'd4, 1'b0, 32'h0,  32'h0, 1'b0};
        vecs[12] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 30'd4, 1'b0, 32'h0,  32'h0, 1'b0};
        vecs[13] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 30'd4, 1'b0, 32'h0,  32'h0, 1'b0};

        // Reset with a request pending: nothing may be accepted.
        reset = 1'b0;
        drive(1'b1, 32'h40, 1'b0, 1'b1);
        @(negedge clock); #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_mem_en", bus.mem_en, 0);
        @(negedge clock); #1;
        check("rst_instr_valid", bus.instr_valid, 0);
        check("rst_instr", bus.instr, 0);
        check("rst_instr_pc", bus.instr_pc, 0);
        check("rst_misaligned", bus.instr_misaligned, 0);
        check("rst_mem_addr", bus.mem_addr, 0);

        // Table: streaming fetch, misaligned fetch, request dropped by flush.
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            reset = 1'b1;
            drive(vecs[i].rv, vecs[i].addr, vecs[i].fl, vecs[i].ir);
            #1;
            check($sformatf("v%0d_req_ready", i), bus.req_ready, vecs[i].e_rr);
            check($sformatf("v%0d_mem_en", i), bus.mem_en, vecs[i].e_me);
            check($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].e_ma);
            check($sformatf("v%0d_instr_valid", i), bus.instr_valid, vecs[i].e_iv);
            check($sformatf("v%0d_instr", i), bus.instr, vecs[i].e_instr);
            check($sformatf("v%0d_instr_pc", i), bus.instr_pc, vecs[i].e_pc);
            check($sformatf("v%0d_misaligned", i), bus.instr_misaligned, vecs[i].e_mis);
        end

        // Backpressure: exactly DEPTH accepts, then drain in order.
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            drive(1'b1, (i < 4) ? 32'h40 + 32'(4 * i) : 32'h50, 1'b0, 1'b0);
            #1;
            check($sformatf("bp%0d_mem_en", i), bus.mem_en, (i < 4) ? 1 : 0);
            if (i >= 4) check($sformatf("bp%0d_req_ready", i), bus.req_ready, 0);
            if (bus.mem_en) accepts++;
        end
        check("bp_accepts", accepts, 4);
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            drive(1'b0, 32'h0, 1'b0, 1'b1);
            #1;
            check($sformatf("dr%0d_instr_valid", j), bus.instr_valid, 1);
            check($sformatf("dr%0d_instr", j), bus.instr, 32'h1A + 32'(j));
            check($sformatf("dr%0d_instr_pc", j), bus.instr_pc, 32'h40 + 32'(4 * j));
            check($sformatf("dr%0d_req_ready", j), bus.req_ready, (j == 0) ? 0 : 1);
        end
        @(negedge clock); #1;
        check("dr_end_instr_valid", bus.instr_valid, 0);
        check("dr_end_req_ready", bus.req_ready, 1);

        // Three queued entries, then flush together with a pop.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drive(1'b1, 32'h80 + 32'(4 * i), 1'b0, 1'b0);
        end
        @(negedge clock);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        drive(1'b1, 32'h8C, 1'b1, 1'b1);
        #1;
        check("fl_head_valid", bus.instr_valid, 1);
        check("fl_head_instr", bus.instr, 32'h2A);
        check("fl_req_ready", bus.req_ready, 0);
        check("fl_mem_en", bus.mem_en, 0);
        @(negedge clock);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        check("fl_after_valid", bus.instr_valid, 0);
        check("fl_after_instr", bus.instr, 0);
        check("fl_after_req_ready", bus.req_ready, 1);
        @(negedge clock); #1;
        check("fl_after2_valid", bus.instr_valid, 0);

        // Reset with two queued and one read outstanding, then a clean fetch.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drive(1'b1, 32'h60 + 32'(4 * i), 1'b0, 1'b0);
        end
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 32'h6C, 1'b0, 1'b0);
        #1;
        check("mr_req_ready", bus.req_ready, 0);
        check("mr_mem_en", bus.mem_en, 0);
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("mr_instr_valid", bus.instr_valid, 0);
        check("mr_instr", bus.instr, 0);
        check("mr_instr_pc", bus.instr_pc, 0);
        check("mr_misaligned", bus.instr_misaligned, 0);
        check("mr_mem_addr", bus.mem_addr, 0);
        check("mr_req_ready_rel", bus.req_ready, 1);
        @(negedge clock);
        drive(1'b1, 32'h20, 1'b0, 1'b1);
        #1;
        check("mr_stale_valid", bus.instr_valid, 0);
        check("mr_fetch_mem_addr", bus.mem_addr, 8);
        @(negedge clock);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        check("mr_wait_valid", bus.instr_valid, 0);
        @(negedge clock); #1;
        check("mr_fetch_valid", bus.instr_valid, 1);
        check("mr_fetch_instr", bus.instr, 32'h12);
        check("mr_fetch_pc", bus.instr_pc, 32'h20);
        @(negedge clock); #1;
        check("mr_fetch_done", bus.instr_valid, 0);

        // Twelve fetches through the full queue: pointer wrap and ordering.
        n_sent = 0;
        n_recv = 0;
        for (int cyc = 0; cyc < 60 && n_recv < 12; cyc++) begin
            @(negedge clock);
            drive(n_sent < 12, 32'h100 + 32'(4 * n_sent), 1'b0, cyc >= 4);
            #1;
            if (cyc == 4) check("wr_full_req_ready", bus.req_ready, 0);
            if (cyc == 5) check("wr_steady_req_ready", bus.req_ready, 1);
            if (bus.instr_valid && bus.instr_ready) begin
                check($sformatf("wr%0d_instr", n_recv), bus.instr, 32'h4A + 32'(n_recv));
                check($sformatf("wr%0d_pc", n_recv), bus.instr_pc, 32'h100 + 32'(4 * n_recv));
                n_recv++;
            end
            if (bus.mem_en) n_sent++;
        end
        check("wr_received", n_recv, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
